// File: rtl/serial_echo_ctrl.sv
// Echo sequencer: pulls bytes from the RX FIFO, drops errored ones, adds a fixed
// increment and hands the result to the transmitter, keeping saturating statistics.
module serial_echo_ctrl #(
  parameter logic [7:0]  INCREMENT      = 8'd1,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned TX_ACK_TIMEOUT = 1024,
  parameter int unsigned TX_GAP_TICKS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_ready,
  input  logic        rx_err,
  input  logic [7:0]  rx_data,
  output logic        rx_read,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [15:0] echo_count,
  output logic [15:0] err_count,
  output logic        active
);

  localparam int unsigned MaxA   = (TX_ACK_TIMEOUT > TX_GAP_TICKS) ? TX_ACK_TIMEOUT : TX_GAP_TICKS;
  localparam int unsigned MaxCnt = (MaxA > READ_LATENCY) ? MaxA : READ_LATENCY;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam int unsigned WaitLastI = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;
  localparam int unsigned AckLastI  = (TX_ACK_TIMEOUT >= 1) ? TX_ACK_TIMEOUT - 1 : 0;
  localparam int unsigned GapLastI  = (TX_GAP_TICKS >= 1) ? TX_GAP_TICKS - 1 : 0;

  localparam logic [CntW-1:0] WaitLast = CntW'(WaitLastI);
  localparam logic [CntW-1:0] AckLast  = CntW'(AckLastI);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapLastI);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWaitData,
    StCheck,
    StSend,
    StWaitAck,
    StWaitDone,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic            hold_err_q, hold_err_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rx_read_q, rx_read_d;
  logic            tx_start_q, tx_start_d;
  logic [15:0]     echo_q, echo_d;
  logic [15:0]     err_q, err_d;
  logic            active_q, active_d;

  logic            ack_timeout;
  logic            echo_inc;
  logic            err_inc;

  assign ack_timeout = (state_q == StWaitAck) && !tx_busy && (cnt_q == AckLast);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_read_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      echo_q      <= '0;
      err_q       <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
      tx_data_q   <= tx_data_d;
      rx_read_q   <= rx_read_d;
      tx_start_q  <= tx_start_d;
      echo_q      <= echo_d;
      err_q       <= err_d;
      active_q    <= active_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (enable && rx_ready) state_d = StRead;
      StRead:     state_d = (READ_LATENCY > 1) ? StWaitData : StCheck;
      StWaitData: if (cnt_q == WaitLast) state_d = StCheck;
      StCheck:    state_d = hold_err_q ? StIdle : StSend;
      StSend:     if (!tx_busy) state_d = StWaitAck;
      StWaitAck: begin
        if (tx_busy)          state_d = StWaitDone;
        else if (ack_timeout) state_d = StIdle;
      end
      StWaitDone: if (!tx_busy) state_d = StGap;
      StGap:      if (cnt_q == GapLast) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath and next values of the registered outputs
  always_comb begin
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    tx_data_d   = tx_data_q;
    echo_d      = echo_q;
    err_d       = err_q;

    // Timer restarts on every state change so each waiting state sees it from zero
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StWaitData || state_q == StWaitAck || state_q == StGap) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (state_d == StCheck && state_q != StCheck) begin
      hold_data_d = rx_data;
      hold_err_d  = rx_err;
    end

    if (state_q == StCheck && !hold_err_q) begin
      tx_data_d = hold_data_q + INCREMENT;
    end

    echo_inc = (state_q == StWaitDone) && !tx_busy;
    err_inc  = ((state_q == StCheck) && hold_err_q) || ack_timeout;

    if (echo_inc && echo_q != 16'hFFFF) echo_d = echo_q + 16'd1;
    if (err_inc && err_q != 16'hFFFF)   err_d  = err_q + 16'd1;

    rx_read_d  = (state_d == StRead);
    tx_start_d = (state_q == StSend) && (state_d == StWaitAck);
    active_d   = (state_d != StIdle);
  end

  assign rx_read    = rx_read_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign echo_count = echo_q;
  assign err_count  = err_q;
  assign active     = active_q;

endmodule

// File: tb/tb_serial_echo_ctrl.sv
// Scoreboard bench for serial_echo_ctrl with behavioural FIFO and transmitter models.
module tb_serial_echo_ctrl;

  localparam logic [7:0]  Inc     = 8'd1;
  localparam int unsigned RdLat   = 2;
  localparam int unsigned AckTo   = 1024;
  localparam int unsigned GapTks  = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_byte_t;

  logic        clk = 1'b0;
  logic        rst, enable, rx_ready, rx_err, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_read, tx_start, active;
  logic [7:0]  tx_data;
  logic [15:0] echo_count, err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rx_byte_t   fifo_q[$];
  logic [7:0] exp_tx[$];
  int         rd_cycs[$];
  int         n_reads = 0;

  // Model controls (written by the main sequence only)
  int   busy_len = 5;
  logic no_ack = 1'b0;
  logic force_busy = 1'b0;
  logic chk_lat = 1'b1;
  int   exp_err = 0;
  int   echo_base = 0;
  // Written by the transmitter model only
  int   echo_done = 0;
  int   busy_left = 0;

  serial_echo_ctrl #(
    .INCREMENT      (Inc),
    .READ_LATENCY   (RdLat),
    .TX_ACK_TIMEOUT (AckTo),
    .TX_GAP_TICKS   (GapTks)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rx_ready   (rx_ready),
    .rx_err     (rx_err),
    .rx_data    (rx_data),
    .rx_read    (rx_read),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .echo_count (echo_count),
    .err_count  (err_count),
    .active     (active)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // RX FIFO model: a read pops the head and presents it until the next read
  initial begin
    rx_byte_t b;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_read === 1'b1) begin
        if (fifo_q.size() == 0) begin
          fail("read_from_empty_fifo");
        end else begin
          b = fifo_q.pop_front();
          rx_data = b.data;
          rx_err  = b.err;
        end
        rd_cycs.push_back(cyc);
        n_reads++;
      end
      rx_ready = (fifo_q.size() != 0);
    end
  end

  // Transmitter model: busy for busy_len cycles after each accepted start
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !no_ack) begin
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) echo_done++;
      end
      tx_busy = force_busy || (busy_left > 0);
    end
  end

  // Monitor: scoreboard on tx_start plus strobe protocol checks
  initial begin
    int         last_rd = 0;
    logic       prev_rd = 1'b0;
    logic       prev_st = 1'b0;
    logic       holding = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (rx_read === 1'b1) begin
          last_rd = cyc;
          if (tx_start === 1'b1) fail("read_start_same_cycle");
          if (prev_rd) fail("read_two_cycles");
        end
        if (tx_start === 1'b1) begin
          if (prev_st) fail("start_two_cycles");
          if (exp_tx.size() == 0) begin
            fail("unexpected_tx_start");
          end else begin
            e = exp_tx.pop_front();
            chk("tx_data", tx_data, e);
          end
          if (chk_lat) chk("start_latency", cyc - last_rd, RdLat + 2);
          held    = tx_data;
          holding = 1'b1;
        end else if (holding) begin
          if (tx_busy === 1'b1) chk("tx_data_stable", tx_data, held);
          else holding = 1'b0;
        end
      end
      prev_rd = (rx_read === 1'b1);
      prev_st = (tx_start === 1'b1);
    end
  end

  task automatic send_byte(input logic err, input logic [7:0] data);
    rx_byte_t   b;
    logic [7:0] v;
    b.err  = err;
    b.data = data;
    fifo_q.push_back(b);
    if (err) begin
      exp_err++;
    end else begin
      v = data + Inc;
      exp_tx.push_back(v);
    end
  endtask

  task automatic wait_read(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rx_read === 1'b1) return;
    end
    fail("wait_read_timeout");
  endtask

  task automatic wait_start(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) return;
    end
    fail("wait_start_timeout");
  endtask

  task automatic drain(input int limit);
    int quiet = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && exp_tx.size() == 0 && active === 1'b0 && tx_busy === 1'b0)
        quiet++;
      else
        quiet = 0;
      if (quiet >= 3) return;
    end
    fail("drain_timeout");
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_echo_count"}, echo_count, echo_done - echo_base);
    chk({tag, "_err_count"}, err_count, exp_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_read"}, rx_read, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_echo_count"}, echo_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_active"}, active, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic e;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst    = 1'b0;
    enable = 1'b1;

    // Good byte with a slow transmitter
    busy_len = 100;
    send_byte(1'b0, 8'h53);
    drain(2000);
    check_counts("good");

    // Wrap-around
    busy_len = 3;
    send_byte(1'b0, 8'hFF);
    drain(500);
    check_counts("wrap");

    // Error drop: back in idle four cycles after the read
    send_byte(1'b1, 8'hA5);
    wait_read(50);
    repeat (4) @(negedge clk);
    chk("err_drop_active", active, 0);
    drain(200);
    check_counts("err_drop");

    // Transmitter never acknowledges
    no_ack = 1'b1;
    send_byte(1'b0, 8'h10);
    wait_start(50);
    repeat (AckTo - 1) @(negedge clk);
    chk("timeout_early", err_count, exp_err);
    exp_err++;
    @(negedge clk);
    chk("timeout_exact", err_count, exp_err);
    no_ack = 1'b0;
    drain(200);
    check_counts("timeout");

    // Busy transmitter holds off the start; three queued bytes
    force_busy = 1'b1;
    chk_lat    = 1'b0;
    rd_cycs.delete();
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h7F);
    send_byte(1'b0, 8'hC3);
    repeat (30) @(negedge clk);
    chk("busy_blocks_start", exp_tx.size(), 3);
    force_busy = 1'b0;
    busy_len   = 4;
    drain(1000);
    chk("three_reads", rd_cycs.size(), 3);
    for (int i = 1; i < rd_cycs.size(); i++)
      chk("read_spacing", (rd_cycs[i] - rd_cycs[i-1]) > int'(GapTks), 1);
    check_counts("three");
    chk_lat = 1'b1;

    // Disable during a long transmission
    busy_len = 60;
    send_byte(1'b0, 8'h20);
    send_byte(1'b0, 8'h21);
    wait_start(50);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    r0 = n_reads;
    repeat (200) @(negedge clk);
    chk("disabled_no_read", n_reads, r0);
    chk("disabled_fifo_left", fifo_q.size(), 1);
    check_counts("disabled");
    enable = 1'b1;
    drain(500);
    check_counts("reenabled");

    // Randomized batches
    for (int k = 0; k < 3; k++) begin
      busy_len = $urandom_range(1, 30);
      for (int j = 0; j < 8; j++) begin
        e = ($urandom_range(0, 3) == 0);
        send_byte(e, 8'($urandom));
      end
      drain(5000);
      check_counts("random");
    end

    // Reset while waiting in SEND; the in-flight byte is discarded
    force_busy = 1'b1;
    begin
      rx_byte_t b;
      b.err  = 1'b0;
      b.data = 8'h44;
      fifo_q.push_back(b);
    end
    wait_read(50);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    echo_base = echo_done;
    exp_err   = 0;
    rst        = 1'b0;
    force_busy = 1'b0;
    repeat (50) @(negedge clk);
    chk("post_reset_active", active, 0);
    check_counts("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
